// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display controller.
// Optional feature macro used by the top: BEST_SCORE_EN.
package score_disp_pkg;

   localparam int DIGITS = 4;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low {dp,g,f,e,d,c,b,a}, dp off
   localparam logic [7:0] SEG_LUT [10] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_CONV,
      S_COMMIT
   } state_t;

   function automatic logic [7:0] seg_code(input logic [3:0] digit);
      logic [7:0] code;
      code = SEG_BLANK;
      if (digit < 4'd10) code = SEG_LUT[digit];
      return code;
   endfunction

   // Digit 0 is always lit; higher digits only up to the most significant nonzero one.
   function automatic logic digit_lit(input logic [15:0] bcd, input logic [1:0] idx);
      logic lit;
      lit = (idx == 2'd0);
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (i >= 32'(idx) && bcd[4*i +: 4] != 4'd0) lit = 1'b1;
      end
      return lit;
   endfunction

endpackage

// File: rtl/score_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per cycle after
// load, combinational done pulse on the cycle performing the final step.
module bin2bcd_seq #(
   parameter int SCORE_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [SCORE_W-1:0] bin,
   output logic               done,
   output logic [15:0]        bcd
);

   localparam int CNT_W = $clog2(SCORE_W + 1);

   logic [SCORE_W-1:0] sr;
   logic [15:0]        acc;
   logic [15:0]        adj;
   logic [CNT_W-1:0]   cnt;
   logic               running;

   always_comb begin
      adj = acc;
      for (int unsigned i = 0; i < 4; i++) begin
         if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

   assign done = running && (cnt == CNT_W'(SCORE_W - 1));
   assign bcd  = acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr      <= '0;
         acc     <= '0;
         cnt     <= '0;
         running <= 1'b0;
      end else if (load) begin
         sr      <= bin;
         acc     <= '0;
         cnt     <= '0;
         running <= 1'b1;
      end else if (running) begin
         acc <= {adj[14:0], sr[SCORE_W-1]};
         sr  <= {sr[SCORE_W-2:0], 1'b0};
         cnt <= cnt + 1'b1;
         if (done) running <= 1'b0;
      end
   end

endmodule

// File: rtl/score_display_ctrl.sv
// 4-digit 7-segment score display sequencer: change detect, BCD conversion,
// atomic commit, digit scan and game-over blink. Optional macro: BEST_SCORE_EN.
module score_display_ctrl
   import score_disp_pkg::*;
#(
   parameter int SCORE_W   = 10,
   parameter int SCAN_DIV  = 100_000,
   parameter int BLINK_DIV = 50_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SCORE_W-1:0] i_score,
   input  logic               i_game_over,
   output logic [7:0]         o_segment,
   output logic [3:0]         o_segment_an,
   output logic               o_busy
);

   localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
   localparam int BLINK_W = $clog2(BLINK_DIV + 1);

   state_t             state;
   state_t             state_next;
   logic [SCORE_W-1:0] last_req;
   logic [15:0]        disp;
   logic               conv_load;
   logic               conv_done;
   logic [15:0]        conv_bcd;

   logic [SCAN_W-1:0]  scan_cnt;
   logic [1:0]         digit_idx;
   logic [BLINK_W-1:0] blink_cnt;
   logic               phase;

   logic [15:0]        src;
   logic               blank_all;
   logic               dp_on;
   logic [7:0]         seg_next;
   logic [3:0]         an_next;

   bin2bcd_seq #(
      .SCORE_W(SCORE_W)
   ) u_conv (
      .clk  (clk),
      .rst  (rst),
      .load (conv_load),
      .bin  (last_req),
      .done (conv_done),
      .bcd  (conv_bcd)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      conv_load  = 1'b0;
      case (state)
         S_IDLE:   if (i_score != last_req) state_next = S_LOAD;
         S_LOAD:   begin
            conv_load  = 1'b1;
            state_next = S_CONV;
         end
         S_CONV:   if (conv_done) state_next = S_COMMIT;
         S_COMMIT: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   assign o_busy = (state != S_IDLE);

   // last_req only moves in IDLE, so it still names the committed value at COMMIT
   always_ff @(posedge clk) begin
      if (rst) begin
         last_req <= '0;
         disp     <= '0;
      end else begin
         if (state == S_IDLE && i_score != last_req) last_req <= i_score;
         if (state == S_COMMIT) disp <= conv_bcd;
      end
   end

`ifdef BEST_SCORE_EN
   logic [SCORE_W-1:0] best_bin;
   logic [15:0]        best_bcd;

   always_ff @(posedge clk) begin
      if (rst) begin
         best_bin <= '0;
         best_bcd <= '0;
      end else if (state == S_COMMIT && last_req > best_bin) begin
         best_bin <= last_req;
         best_bcd <= conv_bcd;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
      end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt  <= '0;
         digit_idx <= digit_idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !i_game_over) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   always_comb begin
      src       = disp;
      blank_all = 1'b0;
      dp_on     = 1'b0;
`ifdef BEST_SCORE_EN
      if (i_game_over && phase) begin
         src   = best_bcd;
         dp_on = 1'b1;
      end
`else
      if (i_game_over && phase) blank_all = 1'b1;
`endif
      seg_next = SEG_BLANK;
      an_next  = 4'hF;
      if (!blank_all && digit_lit(src, digit_idx)) begin
         seg_next = seg_code(src[digit_idx*4 +: 4]);
         if (dp_on && digit_idx == 2'd0) seg_next[7] = 1'b0;
         an_next  = ~(4'b0001 << digit_idx);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_segment    <= SEG_BLANK;
         o_segment_an <= 4'hF;
      end else begin
         o_segment    <= seg_next;
         o_segment_an <= an_next;
      end
   end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed self-checking bench for score_display_ctrl (SCAN_DIV=4, BLINK_DIV=64).
module tb_score_display_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] i_score;
   logic       i_game_over;
   logic [7:0] o_segment;
   logic [3:0] o_segment_an;
   logic       o_busy;

   int compared = 0;
   int mismatched = 0;
   int t = 0;

   logic [7:0] lut [10];

   always #5 clk = ~clk;

   score_display_ctrl #(
      .SCORE_W  (10),
      .SCAN_DIV (4),
      .BLINK_DIV(64)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_score     (i_score),
      .i_game_over (i_game_over),
      .o_segment   (o_segment),
      .o_segment_an(o_segment_an),
      .o_busy      (o_busy)
   );

   task automatic tick();
      @(posedge clk);
      if (rst) t = 0;
      else     t = t + 1;
      #1;
   endtask

   function automatic int slot();
      return ((t - 1) / 4) % 4;
   endfunction

   // Expected {seg, an} for a decimal value shown in a given slot
   function automatic logic [11:0] exp_out(input int s, input int val, input bit dp);
      int d[4];
      int msd;
      logic [7:0] seg;
      d[0] = val % 10;
      d[1] = (val / 10) % 10;
      d[2] = (val / 100) % 10;
      d[3] = val / 1000;
      msd = 0;
      for (int i = 1; i < 4; i++) if (d[i] != 0) msd = i;
      if (s > msd) return {8'hFF, 4'hF};
      seg = lut[d[s]];
      if (dp && s == 0) seg[7] = 1'b0;
      return {seg, ~(4'b0001 << s)};
   endfunction

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, expv, t);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b (t=%0d)", tag, obs, expv, t);
      end
   endtask

   task automatic scan_check(input string tag, input int val, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check(tag, {o_segment, o_segment_an}, exp_out(slot(), val, 1'b0));
      end
   endtask

   initial begin
      int rises;
      bit prev;
      bit seen2;
      logic [11:0] o;
      lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

      rst = 1'b1; i_score = '0; i_game_over = 1'b0;
      tick(); tick();
      check("reset_out", {o_segment, o_segment_an}, {8'hFF, 4'hF});
      check_bit("reset_busy", o_busy, 1'b0);
      rst = 1'b0;
      scan_check("zero_scan", 0, 16);

      // score 12: busy for exactly 12 samples, then display updates
      i_score = 10'd12;
      for (int i = 0; i < 12; i++) begin
         tick();
         check_bit("busy_12", o_busy, 1'b1);
      end
      tick();
      check_bit("busy_12_end", o_busy, 1'b0);
      scan_check("scan_12", 12, 16);

      i_score = 10'd1023;
      for (int i = 0; i < 14; i++) tick();
      scan_check("scan_1023", 1023, 16);

      // 2 then 12 mid-conversion: two conversions, never a torn value
      rises = 0; prev = 1'b0; seen2 = 1'b0;
      i_score = 10'd2;
      for (int k = 0; k < 46; k++) begin
         tick();
         if (o_busy && !prev) rises++;
         prev = o_busy;
         o = {o_segment, o_segment_an};
         if (slot() == 1 && o == exp_out(1, 2, 1'b0)) seen2 = 1'b1;
         compared++;
         assert (o == exp_out(slot(), 1023, 1'b0) || o == exp_out(slot(), 2, 1'b0) ||
                 o == exp_out(slot(), 12, 1'b0)) else begin
            mismatched++;
            $error("FAIL torn: observed %h not a committed value (t=%0d)", o, t);
         end
         if (k == 1) i_score = 10'd12;
      end
      check_bit("commit_count_2", rises == 2, 1'b1);
      check_bit("seen_value_2", seen2, 1'b1);
      scan_check("scan_final_12", 12, 16);

      // reset mid-conversion aborts and restarts from 0 vs i_score
      i_score = 10'd5;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      check("rst_mid_out", {o_segment, o_segment_an}, {8'hFF, 4'hF});
      check_bit("rst_mid_busy", o_busy, 1'b0);
      rst = 1'b0;
      tick();
      check_bit("restart_busy", o_busy, 1'b1);
      for (int i = 0; i < 13; i++) tick();
      scan_check("scan_5", 5, 16);

      i_score = 10'd12;
      for (int i = 0; i < 14; i++) tick();
`ifdef BEST_SCORE_EN
      i_game_over = 1'b1;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (k >= 64) check("go_best_12", {o_segment, o_segment_an}, exp_out(slot(), 12, 1'b1));
         else         check("go_live_12", {o_segment, o_segment_an}, exp_out(slot(), 12, 1'b0));
      end
`else
      i_game_over = 1'b1;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (k >= 64) check("go_off", {o_segment, o_segment_an}, {8'hFF, 4'hF});
         else         check("go_on", {o_segment, o_segment_an}, exp_out(slot(), 12, 1'b0));
      end
`endif
      i_game_over = 1'b0;
      tick();
      check("go_release", {o_segment, o_segment_an}, exp_out(slot(), 12, 1'b0));

`ifdef BEST_SCORE_EN
      rst = 1'b1; i_score = '0;
      tick();
      rst = 1'b0;
      i_score = 10'd50;
      for (int i = 0; i < 14; i++) tick();
      i_score = 10'd30;
      for (int i = 0; i < 14; i++) tick();
      i_game_over = 1'b1;
      for (int k = 0; k < 128; k++) begin
         tick();
         if (k >= 64) check("best_50", {o_segment, o_segment_an}, exp_out(slot(), 50, 1'b1));
         else         check("live_30", {o_segment, o_segment_an}, exp_out(slot(), 30, 1'b0));
      end
      i_game_over = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
